// File: rtl/bitrev_stream_manager.sv
// OBI manager that streams a block of words from memory through the bit-reversal
// subordinate and back to memory, one outstanding transaction at a time.

typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
} mgr_obi_a_chan_t;

typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
} mgr_obi_req_t;

typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
    logic        r_optional;
} mgr_obi_r_chan_t;

typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
} mgr_obi_rsp_t;

module bitrev_stream_manager #(
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned PollLimit = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [31:0]         dev_addr_i,
    input  logic [LenWidth-1:0] len_i,
    output mgr_obi_req_t        obi_req_o,
    input  mgr_obi_rsp_t        obi_rsp_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int unsigned PollW = $clog2(PollLimit + 1);

    typedef enum logic [3:0] {
        StIdle, StSrcA, StSrcR, StInA, StInR, StPollA, StPollR,
        StOutA, StOutR, StDstA, StDstR, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [31:0]         dev_q, dev_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] idx_q, idx_d;
    logic [PollW-1:0]    poll_cnt_q, poll_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0] idx_ext;
    logic [31:0] offset;
    logic        idx_last;
    logic        unused_in;

    assign idx_ext   = 32'(idx_q);
    assign offset    = idx_ext << 2;
    assign idx_last  = (idx_q + LenWidth'(1)) == len_q;
    assign unused_in = ^{src_addr_i[1:0], dst_addr_i[1:0], dev_addr_i[1:0],
                         obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        dev_d      = dev_q;
        len_d      = len_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d      = {src_addr_i[31:2], 2'b00};
                    dst_d      = {dst_addr_i[31:2], 2'b00};
                    dev_d      = {dev_addr_i[31:2], 2'b00};
                    len_d      = len_i;
                    idx_d      = '0;
                    poll_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = (len_i == '0) ? StDone : StSrcA;
                end
            end
            StSrcA:  if (obi_rsp_i.gnt) state_d = StSrcR;
            StInA:   if (obi_rsp_i.gnt) state_d = StInR;
            StPollA: if (obi_rsp_i.gnt) state_d = StPollR;
            StOutA:  if (obi_rsp_i.gnt) state_d = StOutR;
            StDstA:  if (obi_rsp_i.gnt) state_d = StDstR;
            StSrcR, StOutR: begin
                if (obi_rsp_i.rvalid) begin
                    rdata_d = obi_rsp_i.r.rdata;
                    state_d = (state_q == StSrcR) ? StInA : StDstA;
                end
            end
            StInR, StDstR: begin
                if (obi_rsp_i.rvalid) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = (state_q == StInR) ? StPollA : StDone;
                    end else begin
                        idx_d   = idx_q + LenWidth'(1);
                        state_d = (state_q == StInR) ? StSrcA : StPollA;
                    end
                end
            end
            StPollR: begin
                if (obi_rsp_i.rvalid) begin
                    rdata_d = obi_rsp_i.r.rdata;
                    if (obi_rsp_i.r.rdata[0]) begin
                        poll_cnt_d = '0;
                        state_d    = StOutA;
                    end else if (poll_cnt_q == PollW'(PollLimit - 1)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PollW'(1);
                        state_d    = StPollA;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A bus error on any response overrides the normal next step.
        if (obi_rsp_i.rvalid && obi_rsp_i.r.err &&
            (state_q inside {StSrcR, StInR, StPollR, StOutR, StDstR})) begin
            err_d   = 1'b1;
            state_d = StDone;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            dev_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            dev_q      <= dev_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Request fields decode purely from flops, so they hold steady while waiting for gnt.
    always_comb begin
        obi_req_o = '0;
        unique case (state_q)
            StSrcA: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = src_q + offset;
            end
            StInA: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = dev_q;
                obi_req_o.a.we   = 1'b1;
            end
            StPollA: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = dev_q + 32'h8;
            end
            StOutA: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = dev_q + 32'h4;
            end
            StDstA: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = dst_q + offset;
                obi_req_o.a.we   = 1'b1;
            end
            default: ;
        endcase
        if (obi_req_o.req) begin
            obi_req_o.a.be    = 4'hF;
            obi_req_o.a.wdata = rdata_q;
        end
    end

    assign busy_o = (state_q != StIdle) && (state_q != StDone);
    assign done_o = (state_q == StDone);
    assign err_o  = err_q;

endmodule

// File: tb/tb_bitrev_stream_manager.sv
// Bench for bitrev_stream_manager: word memory plus a 4-word bit-reversal subordinate
// answering on OBI, with directed scenarios and hand-computed expectations.

module tb_bitrev_stream_manager;

    localparam int unsigned LenWidth  = 16;
    localparam int unsigned PollLimit = 16;
    localparam logic [31:0] SrcBase   = 32'h0000_0100;
    localparam logic [31:0] DstBase   = 32'h0000_0200;
    localparam logic [31:0] DevBase   = 32'h1000_0000;
    localparam int          SrcIdx    = 'h40;
    localparam int          DstIdx    = 'h80;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [31:0]         src_addr;
    logic [31:0]         dst_addr;
    logic [31:0]         dev_addr;
    logic [LenWidth-1:0] len;
    mgr_obi_req_t        obi_req;
    mgr_obi_rsp_t        obi_rsp;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    always #5 clk = ~clk;

    bitrev_stream_manager #(
        .LenWidth  (LenWidth),
        .PollLimit (PollLimit)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .dev_addr_i (dev_addr),
        .len_i      (len),
        .obi_req_o  (obi_req),
        .obi_rsp_i  (obi_rsp),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // Scenario knobs, written only by the main initial block.
    int          gnt_delay = 0;
    bit          err_en    = 1'b0;
    logic [31:0] err_addr  = '0;
    bit          hold_en   = 1'b0;
    logic [31:0] hold_addr = '0;
    int          clr_gen   = 0;

    // Model and statistics, written only by the responder.
    int          last_gen = -1;
    logic [31:0] mem [1024];
    logic [31:0] dev_in [4];
    logic [1:0]  dev_in_cnt, dev_out_cnt;
    bit          dev_ready;
    bit          pend, pend_err, pend_status, in_req, err_seen, err_at_done;
    logic [31:0] pend_rdata, lat_addr, lat_wdata;
    logic        lat_we;
    int          wait_cnt;
    int          n_reads, n_writes, n_mem_writes, n_req_cycles, n_done, n_busy;
    int          n_zero_polls, n_post_err_req, n_stab_viol;

    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        logic [31:0] a;
        if (clr_gen != last_gen) begin
            last_gen = clr_gen;
            for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
            for (int i = 0; i < 8; i++) mem[SrcIdx + i] = i;
            for (int i = 0; i < 4; i++) dev_in[i] = '0;
            dev_in_cnt = '0; dev_out_cnt = '0; dev_ready = 1'b0;
            pend = 1'b0; pend_err = 1'b0; pend_status = 1'b0; pend_rdata = '0;
            in_req = 1'b0; err_seen = 1'b0; err_at_done = 1'b0; wait_cnt = 0;
            lat_addr = '0; lat_wdata = '0; lat_we = 1'b0;
            n_reads = 0; n_writes = 0; n_mem_writes = 0; n_req_cycles = 0; n_done = 0;
            n_busy = 0; n_zero_polls = 0; n_post_err_req = 0; n_stab_viol = 0;
        end
        obi_rsp = '0;
        if (obi_req.req) n_req_cycles++;
        if (err_seen && obi_req.req) n_post_err_req++;
        if (done_o) begin n_done++; err_at_done = err_o; end
        if (busy_o) n_busy++;
        if (obi_req.req) begin
            if (!in_req) begin
                in_req = 1'b1; lat_addr = obi_req.a.addr;
                lat_we = obi_req.a.we; lat_wdata = obi_req.a.wdata;
            end else if (obi_req.a.addr !== lat_addr || obi_req.a.we !== lat_we ||
                         obi_req.a.wdata !== lat_wdata) begin
                n_stab_viol++;
            end
        end else if (in_req) begin
            n_stab_viol++;
            in_req = 1'b0;
        end
        if (pend) begin
            obi_rsp.rvalid  = 1'b1;
            obi_rsp.r.rdata = pend_rdata;
            obi_rsp.r.err   = pend_err;
            if (pend_err) err_seen = 1'b1;
            if (pend_status && pend_rdata == '0) n_zero_polls++;
            pend = 1'b0;
        end
        if (obi_req.req && !(hold_en && obi_req.a.addr == hold_addr)) begin
            if (wait_cnt < gnt_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0; obi_rsp.gnt = 1'b1; in_req = 1'b0;
                pend = 1'b1; pend_err = 1'b0; pend_status = 1'b0; pend_rdata = '0;
                a = obi_req.a.addr;
                if (err_en && a == err_addr) begin
                    pend_err = 1'b1;
                end else if (obi_req.a.we) begin
                    n_writes++;
                    if (a[31:28] == 4'h1) begin
                        if (a[3:0] == 4'h0) begin
                            dev_in[dev_in_cnt] = obi_req.a.wdata;
                            if (dev_in_cnt == 2'd3) begin dev_ready = 1'b1; dev_out_cnt = '0; end
                            dev_in_cnt = dev_in_cnt + 2'd1;
                        end
                    end else begin
                        mem[a[11:2]] = obi_req.a.wdata;
                        n_mem_writes++;
                    end
                end else begin
                    n_reads++;
                    if (a[31:28] == 4'h1) begin
                        if (a[3:0] == 4'h4) begin
                            pend_rdata = dev_in[{dev_out_cnt[0], dev_out_cnt[1]}];
                            if (dev_out_cnt == 2'd3) dev_ready = 1'b0;
                            dev_out_cnt = dev_out_cnt + 2'd1;
                        end else if (a[3:0] == 4'h8) begin
                            pend_rdata = {31'b0, dev_ready}; pend_status = 1'b1;
                        end
                    end else begin
                        pend_rdata = mem[a[11:2]];
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        clr_gen++;
        @(negedge clk);
    endtask

    // Pulses start with unaligned bases, then scrambles the inputs to prove they were captured.
    task automatic pulse_start(input logic [LenWidth-1:0] l);
        @(negedge clk);
        src_addr = SrcBase + 32'h1; dst_addr = DstBase + 32'h2; dev_addr = DevBase + 32'h3;
        len = l; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        src_addr = 32'hFFFF_FFF0; dst_addr = 32'hFFFF_FFF0; dev_addr = 32'hFFFF_FFF0; len = '1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; src_addr = '0; dst_addr = '0; dev_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (obi_req !== '0) begin n_bad++; $display("FAIL reset_req got %h want 0", obi_req); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_o); end
        rst_i = 1'b0;
    endtask

    task automatic check_dst(input string name);
        logic [31:0] exp_dst [5] = '{32'd0, 32'd2, 32'd1, 32'd3, 32'hDEAD_BEEF};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (mem[DstIdx + i] !== exp_dst[i]) begin
                n_bad++;
                $display("FAIL %s_dst[%0d] got %h want %h", name, i, mem[DstIdx + i], exp_dst[i]);
            end
        end
    endtask

    task automatic run_transfer(input string name, input int delay, input int exp_busy);
        bit ok;
        gnt_delay = delay;
        clear_stats();
        pulse_start(4);
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL %s_busy1 got %b want 1", name, busy_o); end
        n_cmp++; if (obi_req.req !== 1'b1 || obi_req.a.addr !== SrcBase || obi_req.a.we !== 1'b0) begin
            n_bad++; $display("FAIL %s_first_req got req=%b addr=%h we=%b want 1 %h 0",
                              name, obi_req.req, obi_req.a.addr, obi_req.a.we, SrcBase);
        end
        n_cmp++; if (obi_req.a.be !== 4'hF || obi_req.a.aid !== 1'b0 || obi_req.a.a_optional !== 1'b0) begin
            n_bad++; $display("FAIL %s_fields got be=%h aid=%b opt=%b want F 0 0",
                              name, obi_req.a.be, obi_req.a.aid, obi_req.a.a_optional);
        end
        wait_done(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_done_timeout got none want pulse", name); end
        n_cmp++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_at_done got busy=%b err=%b want 0 0", name, busy_o, err_o);
        end
        @(posedge clk); #1;
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", name, done_o); end
        @(negedge clk); #1;
        check_dst(name);
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL %s_done_count got %0d want 1", name, n_done); end
        n_cmp++; if (n_writes !== 8 || n_reads !== 12) begin
            n_bad++; $display("FAIL %s_txn_count got w=%0d r=%0d want 8 12", name, n_writes, n_reads);
        end
        n_cmp++; if (n_busy !== exp_busy) begin
            n_bad++; $display("FAIL %s_busy_cycles got %0d want %0d", name, n_busy, exp_busy);
        end
        n_cmp++; if (n_stab_viol !== 0) begin
            n_bad++; $display("FAIL %s_stability got %0d want 0", name, n_stab_viol);
        end
    endtask

    task automatic test_nominal();
        run_transfer("nominal", 0, 40);
    endtask

    task automatic test_delayed_grant();
        run_transfer("delayed", 3, 100);
    endtask

    task automatic test_zero_length();
        gnt_delay = 0;
        clear_stats();
        pulse_start(0);
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL zero_len_done got done=%b busy=%b err=%b want 1 0 0", done_o, busy_o, err_o);
        end
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (n_req_cycles !== 0) begin n_bad++; $display("FAIL zero_len_req got %0d want 0", n_req_cycles); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL zero_len_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_src_error();
        bit ok;
        err_en = 1'b1; err_addr = SrcBase + 32'h8;
        clear_stats();
        pulse_start(4);
        wait_done(500, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL src_err_timeout got none want pulse"); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL src_err_flag got %b want 1", err_o); end
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (err_at_done !== 1'b1 || err_o !== 1'b1) begin
            n_bad++; $display("FAIL src_err_sticky got at_done=%b now=%b want 1 1", err_at_done, err_o);
        end
        n_cmp++; if (n_mem_writes !== 0 || n_writes !== 2) begin
            n_bad++; $display("FAIL src_err_writes got mem=%0d all=%0d want 0 2", n_mem_writes, n_writes);
        end
        n_cmp++; if (n_post_err_req !== 0) begin n_bad++; $display("FAIL src_err_post_req got %0d want 0", n_post_err_req); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL src_err_done_count got %0d want 1", n_done); end
        err_en = 1'b0;
    endtask

    task automatic test_poll_limit();
        bit ok;
        clear_stats();
        pulse_start(3);
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL poll_err_clear got %b want 0", err_o); end
        wait_done(1000, ok);
        n_cmp++; if (!ok || err_o !== 1'b1) begin
            n_bad++; $display("FAIL poll_abort got done=%b err=%b want 1 1", ok, err_o);
        end
        @(negedge clk); #1;
        n_cmp++; if (n_zero_polls !== PollLimit) begin
            n_bad++; $display("FAIL poll_count got %0d want %0d", n_zero_polls, PollLimit);
        end
        n_cmp++; if (n_reads !== 3 + PollLimit || n_mem_writes !== 0) begin
            n_bad++; $display("FAIL poll_txns got r=%0d memw=%0d want %0d 0", n_reads, n_mem_writes, 3 + PollLimit);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        hold_en = 1'b1; hold_addr = DevBase + 32'h4;
        clear_stats();
        pulse_start(4);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obi_req.req && obi_req.a.addr == hold_addr) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_mid_reach got none want OUT_A request"); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (obi_req.req !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_state got req=%b busy=%b err=%b want 0 0 0", obi_req.req, busy_o, err_o);
        end
        rst_i = 1'b0; hold_en = 1'b0;
        clear_stats();
        pulse_start(4);
        wait_done(500, ok);
        n_cmp++; if (!ok || err_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_restart got done=%b err=%b want 1 0", ok, err_o);
        end
        @(negedge clk); #1;
        check_dst("rst_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_delayed_grant();
        test_zero_length();
        test_src_error();
        test_poll_limit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
